// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game: clock constant, user number width,
// encoder state type and a one-hot to index helper.
package whack_pkg;

   localparam int GAME_CLOCK_FREQ = 50_000;
   localparam int USER_NUM_W      = 4;
   localparam int MAX_BUTTONS     = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HELD = 1'b1
   } enc_state_t;

   // ORs the indices of all set bits; exact only when the caller guarantees one-hot.
   function automatic logic [USER_NUM_W-1:0] onehot_index(input logic [MAX_BUTTONS-1:0] vec);
      logic [USER_NUM_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_BUTTONS; i++) begin
         if (vec[i]) begin
            idx = idx | USER_NUM_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/button_input_encoder_debounce_vec.sv
// Two-flop synchronizer followed by a whole-vector debouncer sharing one settle counter.
module debounce_vec #(
   parameter int N      = 16,
   parameter int CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_raw,
   output logic [N-1:0] o_stable
);

   localparam int                CNT_W    = $clog2(CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

   logic [N-1:0]     r_meta;
   logic [N-1:0]     r_sync;
   logic [N-1:0]     r_cand;
   logic [N-1:0]     r_stable;
   logic [CNT_W-1:0] r_cnt;

   // synchronizer chain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
      end
   end

   // any change of the candidate restarts the settle count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cand   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else if (r_sync != r_cand) begin
         r_cand <= r_sync;
         r_cnt  <= '0;
      end else if ((r_cand != r_stable) && (r_cnt == CNT_LAST)) begin
         r_stable <= r_cand;
         r_cnt    <= '0;
      end else if (r_cand != r_stable) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/button_input_encoder.sv
// Debounces the mole buttons and turns each clean single press into a one-cycle
// user_valid/user_number strobe; simultaneous presses raise multi_press instead.
module button_input_encoder
   import whack_pkg::*;
#(
   parameter int CLOCK_FREQ  = whack_pkg::GAME_CLOCK_FREQ,
   parameter int DEBOUNCE_MS = 10,
   parameter int N_BUTTONS   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_BUTTONS-1:0]  btn_raw,
   input  logic                  enable,
   output logic                  user_valid,
   output logic [USER_NUM_W-1:0] user_number,
   output logic                  multi_press,
   output logic [N_BUTTONS-1:0]  btn_stable
);

   localparam int DEBOUNCE_CYCLES = CLOCK_FREQ * DEBOUNCE_MS / 1000;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("button_input_encoder: DEBOUNCE_CYCLES must be at least 1");
   end
   if ((N_BUTTONS < 1) || (N_BUTTONS > MAX_BUTTONS)) begin : g_bad_width
      $error("button_input_encoder: N_BUTTONS must be within 1..16");
   end

   logic [N_BUTTONS-1:0]   w_stable;
   logic [MAX_BUTTONS-1:0] w_stable_ext;
   logic                   w_any;
   logic                   w_multi;

   enc_state_t             r_state;
   logic                   r_user_valid;
   logic                   r_multi_press;
   logic [USER_NUM_W-1:0]  r_user_number;

   debounce_vec #(
      .N      (N_BUTTONS),
      .CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_raw),
      .o_stable (w_stable)
   );

   // widen to 16 bits so unused high user_number bits come out as zero
   always_comb begin
      w_stable_ext                  = '0;
      w_stable_ext[N_BUTTONS-1:0]   = w_stable;
   end

   assign w_any   = |w_stable_ext;
   assign w_multi = |(w_stable_ext & (w_stable_ext - MAX_BUTTONS'(1)));

   // enable is only looked at when leaving IDLE; HELD waits for a full release
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_user_valid  <= 1'b0;
         r_multi_press <= 1'b0;
         r_user_number <= '0;
      end else begin
         r_user_valid  <= 1'b0;
         r_multi_press <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= HELD;
                  if (enable && !w_multi) begin
                     r_user_valid  <= 1'b1;
                     r_user_number <= onehot_index(w_stable_ext);
                  end else if (enable) begin
                     r_multi_press <= 1'b1;
                  end
               end
            end
            HELD: begin
               if (!w_any) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign user_valid  = r_user_valid;
   assign multi_press = r_multi_press;
   assign user_number = r_user_number;
   assign btn_stable  = w_stable;

endmodule

// File: tb/tb_button_input_encoder.sv
// Scoreboard bench: a window-based reference model predicts every strobe and the
// debounced vector for a 16-button and a 4-button instance.
module tb_button_input_encoder;

   localparam int CF  = 1000;
   localparam int DMS = 4;
   localparam int DC  = CF * DMS / 1000;
   localparam int LAT = DC + 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] btn_raw;

   logic        uv0, mp0, uv1, mp1;
   logic [3:0]  un0, un1;
   logic [15:0] bs0;
   logic [3:0]  bs1;

   always #5 clk = ~clk;

   button_input_encoder #(.CLOCK_FREQ(CF), .DEBOUNCE_MS(DMS), .N_BUTTONS(16)) u_dut16 (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .enable(enable),
      .user_valid(uv0), .user_number(un0), .multi_press(mp0), .btn_stable(bs0)
   );

   button_input_encoder #(.CLOCK_FREQ(CF), .DEBOUNCE_MS(DMS), .N_BUTTONS(4)) u_dut4 (
      .clk(clk), .rst(rst), .btn_raw(btn_raw[3:0]), .enable(enable),
      .user_valid(uv1), .user_number(un1), .multi_press(mp1), .btn_stable(bs1)
   );

   typedef struct {
      bit is_multi;
      int num;
      int cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   bit          mon_en = 1'b0;

   logic [15:0] hist [2][DC+3];
   logic [15:0] m_stable [2];
   logic [15:0] m_prev [2];
   int          m_num [2];
   int          uv_cnt [2];
   int          mp_cnt [2];
   int          last_cyc [2];
   int          last_num [2];
   int          uv_base [2];
   int          mp_base [2];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic push_exp(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Reference: the debounced vector takes value v once the last DC+1 raw samples
   // (ignoring the newest one, still in the synchronizer) all equal v. A strobe
   // fires one cycle after the vector leaves zero, if enable is high then.
   task automatic model_step();
      logic [15:0] mask;
      logic [15:0] v;
      bit          same;
      exp_t        e;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         mask = (d == 0) ? 16'hFFFF : 16'h000F;
         if (rst) begin
            for (int j = 0; j < DC + 3; j++) hist[d][j] = 16'h0000;
            m_stable[d] = 16'h0000;
            m_prev[d]   = 16'h0000;
            m_num[d]    = 0;
         end else begin
            if ((m_stable[d] != 16'h0000) && (m_prev[d] == 16'h0000) && enable) begin
               e.cyc = cyc;
               if ($countones(m_stable[d]) == 1) begin
                  e.is_multi = 1'b0;
                  for (int j = 0; j < 16; j++) if (m_stable[d][j]) e.num = j;
                  m_num[d] = e.num;
               end else begin
                  e.is_multi = 1'b1;
                  e.num      = m_num[d];
               end
               push_exp(d, e);
            end
            v    = hist[d][1];
            same = 1'b1;
            for (int j = 2; j <= DC + 1; j++) if (hist[d][j] != v) same = 1'b0;
            m_prev[d] = m_stable[d];
            if (same) m_stable[d] = v;
            for (int j = DC + 2; j > 0; j--) hist[d][j] = hist[d][j-1];
            hist[d][0] = btn_raw & mask;
         end
      end
      if (rst) mon_en = 1'b1;
   endtask

   task automatic mon_dut(input int d, input logic uv, input logic mp, input int un, input int bs);
      exp_t e;
      int   qs;
      qs = (d == 0) ? q0.size() : q1.size();
      chk($sformatf("strobe_overlap_d%0d", d), int'(uv && mp), 0);
      if (uv || mp) begin
         if (qs == 0) begin
            chk($sformatf("unexpected_strobe_d%0d", d), int'(uv) + 2 * int'(mp), 0);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("strobe_kind_multi_d%0d", d), int'(mp), int'(e.is_multi));
            chk($sformatf("strobe_cycle_d%0d", d), cyc, e.cyc);
            if (uv) chk($sformatf("strobe_number_d%0d", d), un, e.num);
         end
         if (uv) begin
            uv_cnt[d]++;
            last_cyc[d] = cyc;
            last_num[d] = un;
         end else begin
            mp_cnt[d]++;
         end
      end else if (qs > 0) begin
         e = (d == 0) ? q0[0] : q1[0];
         if (e.cyc <= cyc) begin
            chk($sformatf("missing_strobe_d%0d", d), cyc, e.cyc + 1000000);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
         end
      end
      chk($sformatf("btn_stable_d%0d", d), bs, int'(m_stable[d]));
      chk($sformatf("user_number_held_d%0d", d), un, m_num[d]);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            mon_dut(0, uv0, mp0, int'(un0), int'(bs0));
            mon_dut(1, uv1, mp1, int'(un1), int'(bs1));
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      for (int d = 0; d < 2; d++) begin
         uv_base[d] = uv_cnt[d];
         mp_base[d] = mp_cnt[d];
      end
   endtask

   task automatic release_all();
      btn_raw = 16'h0000;
      wait_cyc(LAT + 4);
   endtask

   initial begin
      int n;
      int d;
      int idx;
      for (int k = 0; k < 2; k++) begin
         uv_cnt[k] = 0; mp_cnt[k] = 0; last_cyc[k] = -1; last_num[k] = -1;
      end
      rst     = 1'b1;
      enable  = 1'b1;
      btn_raw = 16'h0000;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(4);

      // clean press of button 9
      snap();
      btn_raw[9] = 1'b1;
      n = cyc;
      wait_cyc(LAT + 6);
      chk("s1_pulse_count", uv_cnt[0] - uv_base[0], 1);
      chk("s1_latency", last_cyc[0], n + LAT);
      chk("s1_number", last_num[0], 9);
      chk("s1_narrow_silent", uv_cnt[1] - uv_base[1], 0);
      release_all();

      // bounce on button 3, then hold
      snap();
      n = 0;
      while (n < 20) begin
         btn_raw[3] = ~btn_raw[3];
         d = $urandom_range(1, 3);
         wait_cyc(d);
         n += d;
      end
      if (btn_raw[3]) begin
         btn_raw[3] = 1'b0;
         wait_cyc(1);
      end
      chk("s2_no_pulse_in_bounce", uv_cnt[0] - uv_base[0], 0);
      btn_raw[3] = 1'b1;
      n = cyc;
      wait_cyc(LAT + 6);
      chk("s2_pulse_count", uv_cnt[0] - uv_base[0], 1);
      chk("s2_latency", last_cyc[0], n + LAT);
      chk("s2_number", last_num[0], 3);
      release_all();

      // simultaneous press of 2 and 5
      snap();
      btn_raw[2] = 1'b1;
      btn_raw[5] = 1'b1;
      wait_cyc(LAT + 4);
      chk("s3_multi_count", mp_cnt[0] - mp_base[0], 1);
      chk("s3_no_valid", uv_cnt[0] - uv_base[0], 0);
      btn_raw[2] = 1'b0;
      wait_cyc(LAT + 4);
      chk("s3_partial_release_silent", uv_cnt[0] - uv_base[0], 0);
      release_all();
      snap();
      btn_raw[5] = 1'b1;
      n = cyc;
      wait_cyc(LAT + 4);
      chk("s3_repress_count", uv_cnt[0] - uv_base[0], 1);
      chk("s3_repress_number", last_num[0], 5);
      chk("s3_repress_latency", last_cyc[0], n + LAT);
      release_all();

      // reset in the middle of settling button 7
      snap();
      btn_raw[7] = 1'b1;
      wait_cyc(5);
      rst = 1'b1;
      wait_cyc(1);
      chk("s5_rst_number", int'(un0), 0);
      chk("s5_rst_valid", int'(uv0), 0);
      chk("s5_rst_multi", int'(mp0), 0);
      rst = 1'b0;
      n = cyc;
      wait_cyc(LAT + 4);
      chk("s5_pulse_count", uv_cnt[0] - uv_base[0], 1);
      chk("s5_latency", last_cyc[0], n + LAT);
      chk("s5_number", last_num[0], 7);
      release_all();

      // enable gating: held across enable rising does not fire
      snap();
      enable = 1'b0;
      btn_raw[0] = 1'b1;
      wait_cyc(LAT + 4);
      enable = 1'b1;
      wait_cyc(LAT);
      chk("s4_gated_silent", uv_cnt[0] - uv_base[0], 0);
      chk("s4_gated_silent_narrow", uv_cnt[1] - uv_base[1], 0);
      btn_raw[0] = 1'b0;
      wait_cyc(LAT);
      btn_raw[0] = 1'b1;
      n = cyc;
      wait_cyc(LAT + 4);
      chk("s4_pulse_count", uv_cnt[0] - uv_base[0], 1);
      chk("s4_number", last_num[0], 0);
      chk("s4_latency", last_cyc[0], n + LAT);
      release_all();

      // narrow instance: top button then button 0
      snap();
      btn_raw[3] = 1'b1;
      wait_cyc(LAT + 4);
      chk("s6_pulse_count", uv_cnt[1] - uv_base[1], 1);
      chk("s6_number", last_num[1], 3);
      chk("s6_btn_stable", int'(bs1), 8);
      release_all();
      btn_raw[0] = 1'b1;
      wait_cyc(LAT + 4);
      chk("s6_number_low", last_num[1], 0);
      release_all();

      // randomized presses, bounces, glitches, enable toggles and resets
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 6))
            0: begin
               idx = $urandom_range(0, 15);
               btn_raw = 16'h0000;
               btn_raw[idx] = 1'b1;
            end
            1: btn_raw = 16'($urandom);
            2: btn_raw = 16'h0000;
            3: begin
               idx = $urandom_range(0, 15);
               btn_raw[idx] = ~btn_raw[idx];
            end
            4: enable = ~enable;
            5: begin
               rst = 1'b1;
               wait_cyc(1);
               rst = 1'b0;
            end
            default: begin
               idx = $urandom_range(0, 15);
               btn_raw[idx] = ~btn_raw[idx];
               wait_cyc($urandom_range(1, DC));
               btn_raw[idx] = ~btn_raw[idx];
            end
         endcase
         wait_cyc($urandom_range(1, 14));
      end
      enable  = 1'b1;
      btn_raw = 16'h0000;
      wait_cyc(LAT + 10);
      chk("pending_strobes_wide", q0.size(), 0);
      chk("pending_strobes_narrow", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_input_encoder.md
# button_input_encoder

Player-side front end for the whack-a-mole game core. It synchronizes and debounces the raw mole buttons, then encodes each clean single press into the one-cycle `user_valid` / `user_number` strobe the game core consumes. Simultaneous presses are rejected and flagged. The block sits between the board pins and the game core's user input port.

## Interface

**Parameters**
- `CLOCK_FREQ`, default 50_000: master clock frequency in Hz.
- `DEBOUNCE_MS`, default 10: debounce settle time in ms.
- `N_BUTTONS`, default 16: number of buttons. Legal range 1..16.
- Derived localparam `DEBOUNCE_CYCLES = CLOCK_FREQ*DEBOUNCE_MS/1000`. Must be ≥1; elaboration error otherwise.

**Ports**
- `clk` in 1: master clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in N_BUTTONS: asynchronous raw buttons, active-high.
- `enable` in 1: core accepting input; driven as `!game_over`.
- `user_valid` out 1: one-cycle pulse for each accepted press.
- `user_number` out 4: index of the accepted button. Valid with `user_valid`, held afterwards.
- `multi_press` out 1: one-cycle pulse when more than one button settles pressed from idle.
- `btn_stable` out N_BUTTONS: debounced button vector, for LEDs and debug.

## Operation

**Synchronizer**
- 2-flop synchronizer per bit. Output is `sync`.

**Debouncer** (whole-vector, one shared counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`)
- `sync != cand`: `cand <= sync`, `cnt <= 0`.
- Else if `cand != btn_stable` and `cnt == DEBOUNCE_CYCLES-1`: `btn_stable <= cand`, `cnt <= 0`.
- Else if `cand != btn_stable`: `cnt <= cnt+1`.
- Else: `cnt <= 0`.
- Any change of the vector during settling restarts the count.

**Encoder FSM** (acts on `btn_stable`)
- IDLE
  - `btn_stable == 0`: stay.
  - `enable` and exactly one bit set (bit i): `user_valid <= 1`, `user_number <= i`, go to HELD.
  - `enable` and ≥2 bits set: `multi_press <= 1`, no valid, go to HELD.
  - `!enable` and any bit set: go to HELD silently.
- HELD
  - `btn_stable == 0`: go to IDLE.
  - Otherwise stay. Adding or removing buttons while any remain pressed never emits.
- `enable` is sampled only in IDLE. Dropping `enable` while in HELD has no effect.
- A button held across `enable` rising does not fire; it must be released and pressed again.

**Outputs**
- `user_valid` and `multi_press` are registered and never asserted in the same cycle.
- Unused high `user_number` bits are 0 when `N_BUTTONS < 16`.

**Reset** (synchronous, may arrive mid-operation)
- Synchronizer flops, `cand`, `btn_stable` and `cnt` → 0.
- FSM → IDLE.
- `user_valid`, `multi_press`, `user_number` → 0.
- A button held through reset release settles as a fresh press: `DEBOUNCE_CYCLES+4` cycles after release it emits, if `enable` is high.

## Timing
- Raw edge to `sync` change: 2 cycles.
- `sync` change to `btn_stable` update: `DEBOUNCE_CYCLES+1` cycles.
- `btn_stable` update to `user_valid` / `multi_press`: 1 cycle.
- Total raw-to-strobe: `DEBOUNCE_CYCLES+4` cycles (504 at defaults).
- Release latency to IDLE: `DEBOUNCE_CYCLES+4` cycles.
- Maximum press rate: one accepted press per 2·(`DEBOUNCE_CYCLES+1`) cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) never change `btn_stable`.
- No backpressure: the game core must accept `user_valid` in any cycle.

## Structure
- Shared package `whack_pkg` holds:
  - `USER_NUM_W = 4`;
  - FSM state enum `enc_state_t` {IDLE, HELD};
  - a `onehot_index` function (priority-free; caller guarantees one-hot).
- `CLOCK_FREQ` comes from the same package constant the game top uses.
- One sub-module, `debounce_vec`: synchronizer, `cand`, `cnt` and `btn_stable` for an N-bit vector.
- `button_input_encoder` instantiates `debounce_vec` and contains the FSM and the popcount/one-hot check.

## Test plan
All scenarios use `CLOCK_FREQ=1000`, `DEBOUNCE_MS=4` (so `DEBOUNCE_CYCLES=4`) and `N_BUTTONS=16` unless stated.

1. **Clean press**: raise `btn_raw[9]` with `enable=1` and hold → `user_valid` high for exactly one cycle, 8 cycles after the edge, with `user_number=9`. No further pulses until release.
2. **Bounce rejection**: toggle `btn_raw[3]` with periods of 1–3 cycles for 20 cycles, then hold high → no `user_valid` during the bounce. Exactly one pulse with `user_number=3`, 8 cycles after the last edge.
3. **Multi-press**: raise bits 2 and 5 in the same cycle → `multi_press` pulses once and `user_valid` stays 0. Release 2 while holding 5 → no emit. Release both, then press 5 → `user_valid`, `user_number=5`.
4. **Enable gating**: hold `btn_raw[0]` while `enable=0`, then raise `enable` → no pulse. Release, wait 8 cycles, press 0 → one pulse with `user_number=0`.
5. **Reset mid-operation**: assert `rst` for 1 cycle at cycle 5 of the settling window for `btn_raw[7]`, still held → all outputs 0 during reset. One `user_valid` with `user_number=7` occurs 8 cycles after `rst` deasserts.
6. **Width edge**: with `N_BUTTONS=4`, press bit 3 → `user_number=4'b0011` and `btn_stable=4'b1000`. Then press bit 0 after release → `user_number=0`.
